// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU and the result FIFO consumer.
// slave = FIFO view, master = producer/consumer view.
interface alu_result_fifo_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [2:0]       in_command;
  logic             in_carryout;
  logic             in_zero;
  logic             in_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_command;
  logic             out_carryout;
  logic             out_zero;
  logic             out_overflow;

  modport slave (
    input  in_valid, in_result, in_command,
    input  in_carryout, in_zero, in_overflow,
    input  out_ready,
    output in_ready, out_valid, out_result,
    output out_command, out_carryout,
    output out_zero, out_overflow
  );

  modport master (
    output in_valid, in_result, in_command,
    output in_carryout, in_zero, in_overflow,
    output out_ready,
    input  in_ready, out_valid, out_result,
    input  out_command, out_carryout,
    input  out_zero, out_overflow
  );
endinterface

// File: rtl/alu_result_fifo.sv
// In-order FIFO of ALU results + flags, valid/ready both sides.
// Optional sticky carry/overflow bits: define ALU_STICKY_FLAGS_EN.
module alu_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  alu_result_fifo_if.slave bus,
`ifdef ALU_STICKY_FLAGS_EN
  input  logic          sticky_clear,
  output logic          sticky_carry,
  output logic          sticky_overflow,
`endif
  output logic [AW:0]   count
);

  localparam int EW = WIDTH + 6;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [EW-1:0] w_in;
  logic [EW-1:0] w_head;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid & ~w_full & ~reset;
  assign w_pop   = bus.out_ready & ~w_empty & ~reset;

  assign w_in = {bus.in_result, bus.in_command,
                 bus.in_carryout, bus.in_zero,
                 bus.in_overflow};

  // Storage is never cleared; the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign bus.in_ready     = ~w_full;
  assign bus.out_valid    = ~w_empty;
  assign bus.out_result   = w_head[EW-1:6];
  assign bus.out_command  = w_head[5:3];
  assign bus.out_carryout = w_head[2];
  assign bus.out_zero     = w_head[1];
  assign bus.out_overflow = w_head[0];
  assign count            = r_count;

`ifdef ALU_STICKY_FLAGS_EN
  logic r_sticky_carry;
  logic r_sticky_overflow;
  logic w_arith;

  // ADD=0 and SUB=1 are the only commands with meaningful C/V.
  assign w_arith = w_push & (bus.in_command[2:1] == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky_carry    <= 1'b0;
      r_sticky_overflow <= 1'b0;
    end else begin
      if (w_arith & bus.in_carryout)
        r_sticky_carry <= 1'b1;
      else if (sticky_clear)
        r_sticky_carry <= 1'b0;
      if (w_arith & bus.in_overflow)
        r_sticky_overflow <= 1'b1;
      else if (sticky_clear)
        r_sticky_overflow <= 1'b0;
    end
  end

  assign sticky_carry    = r_sticky_carry;
  assign sticky_overflow = r_sticky_overflow;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed steps then random traffic,
// checked against a queue model of the FIFO.
module tb_alu_result_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [AW:0] count;
`ifdef ALU_STICKY_FLAGS_EN
  logic sticky_clear;
  logic sticky_carry;
  logic sticky_overflow;
  logic m_sc;
  logic m_so;
`endif

  int checks = 0;
  int errors = 0;

  logic [37:0] q[$];

  alu_result_fifo_if #(.WIDTH(WIDTH)) bus ();

  alu_result_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
`ifdef ALU_STICKY_FLAGS_EN
    .sticky_clear(sticky_clear),
    .sticky_carry(sticky_carry),
    .sticky_overflow(sticky_overflow),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] mk(
    input logic [31:0] r, input logic [2:0] c,
    input logic cf, input logic zf, input logic of);
    return {r, c, cf, zf, of};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [37:0] h;
    h = (q.size() != 0) ? q[0] : '0;
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(bus.in_ready),
        64'(q.size() != DEPTH));
    chk("out_valid", 64'(bus.out_valid),
        64'(q.size() != 0));
    chk("out_result", 64'(bus.out_result), 64'(h[37:6]));
    chk("out_command", 64'(bus.out_command), 64'(h[5:3]));
    chk("out_carry", 64'(bus.out_carryout), 64'(h[2]));
    chk("out_zero", 64'(bus.out_zero), 64'(h[1]));
    chk("out_ovf", 64'(bus.out_overflow), 64'(h[0]));
`ifdef ALU_STICKY_FLAGS_EN
    chk("sticky_carry", 64'(sticky_carry), 64'(m_sc));
    chk("sticky_ovf", 64'(sticky_overflow), 64'(m_so));
`endif
  endtask

  task automatic cycle(input logic v, input logic [37:0] e,
                       input logic rdy, input logic rst,
                       input logic clr);
    bit push, pop, arith;
    bus.in_valid = v;
    {bus.in_result, bus.in_command, bus.in_carryout,
     bus.in_zero, bus.in_overflow} = e;
    bus.out_ready = rdy;
    reset = rst;
`ifdef ALU_STICKY_FLAGS_EN
    sticky_clear = clr;
`endif
    push  = v && (q.size() < DEPTH) && !rst;
    pop   = rdy && (q.size() > 0) && !rst;
    arith = push && (e[5:3] == 3'd0 || e[5:3] == 3'd1);
    @(posedge clk);
    if (rst) begin
      q.delete();
`ifdef ALU_STICKY_FLAGS_EN
      m_sc = 1'b0;
      m_so = 1'b0;
`endif
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
`ifdef ALU_STICKY_FLAGS_EN
      if (arith && e[2]) m_sc = 1'b1;
      else if (clr)      m_sc = 1'b0;
      if (arith && e[0]) m_so = 1'b1;
      else if (clr)      m_so = 1'b0;
`endif
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [37:0] z;
    z = '0;
`ifdef ALU_STICKY_FLAGS_EN
    m_sc = 1'b0;
    m_so = 1'b0;
`endif
    cycle(1'b1, mk(32'hdead, 3'd0, 1, 1, 1), 1'b0, 1'b1, 1'b0);
    cycle(1'b0, z, 1'b0, 1'b1, 1'b0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);

    // 1: single push visible next cycle
    cycle(1'b1, mk(32'h3, 3'd0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_result", 64'(bus.out_result), 64'h3);
    chk("t1_count", 64'(count), 64'd1);
    cycle(1'b0, z, 1'b1, 1'b0, 1'b0);

    // 2: fill, overflow push dropped, drain
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, mk(32'(i), 3'(i), 0, 1, 0),
            1'b0, 1'b0, 1'b0);
    chk("t2_full_cnt", 64'(count), 64'd4);
    chk("t2_ready", 64'(bus.in_ready), 64'd0);
    cycle(1'b1, mk(32'h5, 3'd5, 1, 1, 1), 1'b0, 1'b0, 1'b0);
    chk("t2_drop_cnt", 64'(count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_pop", 64'(bus.out_result), 64'(i));
      cycle(1'b0, z, 1'b1, 1'b0, 1'b0);
    end
    chk("t2_empty", 64'(bus.out_valid), 64'd0);
    chk("t2_zero", 64'(bus.out_result), 64'd0);

    // 3: steady push+pop at count 2, pointers wrap
    cycle(1'b1, mk(32'h100, 3'd7, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(32'h101, 3'd6, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, mk(32'h102 + 32'(i), 3'd3, 0, 0, 1),
            1'b1, 1'b0, 1'b0);
      chk("t3_count", 64'(count), 64'd2);
    end
    chk("t3_head", 64'(bus.out_result), 64'h108);

    // 4: reset with in_valid high discards everything
    cycle(1'b1, mk(32'haa, 3'd4, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    chk("t4_cnt3", 64'(count), 64'd3);
    cycle(1'b1, mk(32'hbb, 3'd4, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_ready", 64'(bus.in_ready), 64'd1);

`ifdef ALU_STICKY_FLAGS_EN
    // 5: sticky overflow set / hold / clear / set wins
    cycle(1'b1, mk(32'h7fffffff, 3'd1, 0, 0, 1),
          1'b0, 1'b0, 1'b0);
    chk("t5_set", 64'(sticky_overflow), 64'd1);
    cycle(1'b0, z, 1'b1, 1'b0, 1'b0);
    chk("t5_hold", 64'(sticky_overflow), 64'd1);
    cycle(1'b0, z, 1'b0, 1'b0, 1'b1);
    chk("t5_clr", 64'(sticky_overflow), 64'd0);
    cycle(1'b1, mk(32'h1, 3'd0, 0, 0, 1), 1'b1, 1'b0, 1'b1);
    chk("t5_win", 64'(sticky_overflow), 64'd1);
    cycle(1'b0, z, 1'b1, 1'b0, 1'b1);

    // 6: logic command flags never set sticky bits
    cycle(1'b1, mk(32'h55, 3'd2, 1, 0, 1), 1'b0, 1'b0, 1'b0);
    chk("t6_sc", 64'(sticky_carry), 64'd0);
    chk("t6_so", 64'(sticky_overflow), 64'd0);
    chk("t6_c", 64'(bus.out_carryout), 64'd1);
    chk("t6_o", 64'(bus.out_overflow), 64'd1);
    cycle(1'b0, z, 1'b1, 1'b0, 1'b0);
`endif

    // random traffic with phases biased to fill and drain
    for (int i = 0; i < 600; i++) begin
      int ph;
      logic v, rdy, rst, clr;
      ph  = (i / 100) % 3;
      v   = ($urandom_range(0, 3) < (ph == 2 ? 1 : 3));
      rdy = ($urandom_range(0, 3) < (ph == 0 ? 1 : 3));
      rst = ($urandom_range(0, 79) == 0);
      clr = ($urandom_range(0, 7) == 0);
      cycle(v, mk($urandom, 3'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), 1'($urandom)),
            rdy, rst, clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
